// File: rtl/dense_deserial_pkg.sv
// Shared definitions for the dense1 serial/parallel framing blocks:
// FSM state encoding and default frame geometry.
package dense_deserial_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_HOLD    = 2'd2
   } frame_state_t;

   localparam int DENSE_N  = 120;
   localparam int DENSE_DW = 16;

endpackage

// File: rtl/dense_deserial.sv
// Serial-to-parallel frame deserialiser: collects N signed words into one frame
// and holds it until downstream accepts. Define DESERIAL_LEN_CHECK_EN to add err_len.
module dense_deserial
   import dense_deserial_pkg::*;
#(
   parameter int N  = DENSE_N,
   parameter int DW = DENSE_DW
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 valid_in,
   input  logic                 frame_start_in,
   input  logic                 frame_end_in,
   input  logic signed [DW-1:0] data_in,
   input  logic                 out_ready,
   output logic                 out_valid,
   output logic [N*DW-1:0]      frame_out,
`ifdef DESERIAL_LEN_CHECK_EN
   output logic                 overrun,
   output logic                 err_len
`else
   output logic                 overrun
`endif
);

   localparam int             CW  = $clog2(N + 1);
   localparam logic [CW-1:0]  N_C = CW'(N);

   frame_state_t     state_q, state_d;
   logic [CW-1:0]    count_q, count_d;
   logic [N*DW-1:0]  frame_q, frame_d;
   logic             overrun_q, overrun_d;
   logic             err_q, err_d;
   logic             take;

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      frame_d   = frame_q;
      overrun_d = 1'b0;
      err_d     = 1'b0;
      take      = 1'b0;

      unique case (state_q)
         ST_IDLE:    take = valid_in && frame_start_in;
         ST_COLLECT: take = valid_in;
         ST_HOLD: begin
            // A start word may ride on the handshake cycle; anything else is lost.
            if (out_ready) begin
               state_d = ST_IDLE;
               count_d = '0;
               take    = valid_in && frame_start_in;
            end
            overrun_d = valid_in && !take;
         end
         default: state_d = ST_IDLE;
      endcase

      if (take) begin
         if (frame_start_in) begin
            frame_d          = '0;
            frame_d[DW-1:0]  = data_in;
            count_d          = CW'(1);
            state_d          = ST_COLLECT;
         end else if (count_q < N_C) begin
            frame_d[int'(count_q)*DW +: DW] = data_in;
            count_d                         = count_q + CW'(1);
         end else begin
`ifdef DESERIAL_LEN_CHECK_EN
            err_d   = 1'b1;
            state_d = ST_IDLE;
            count_d = '0;
`endif
         end

         if (frame_end_in && state_d == ST_COLLECT) begin
`ifdef DESERIAL_LEN_CHECK_EN
            if (count_d != N_C) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
               count_d = '0;
            end else begin
               state_d = ST_HOLD;
            end
`else
            state_d = ST_HOLD;
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         count_q   <= '0;
         frame_q   <= '0;
         overrun_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         frame_q   <= frame_d;
         overrun_q <= overrun_d;
         err_q     <= err_d;
      end
   end

   assign out_valid = (state_q == ST_HOLD);
   assign frame_out = frame_q;
   assign overrun   = overrun_q;
`ifdef DESERIAL_LEN_CHECK_EN
   assign err_len   = err_q;
`else
   logic unused_err;
   assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_dense_deserial.sv
// Self-checking bench for dense_deserial: queue-based frame model plus directed scenarios.
module tb_dense_deserial;
   import dense_deserial_pkg::*;

   localparam int N  = DENSE_N;
   localparam int DW = DENSE_DW;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 valid_in = 1'b0;
   logic                 frame_start_in = 1'b0;
   logic                 frame_end_in = 1'b0;
   logic signed [DW-1:0] data_in = '0;
   logic                 out_ready = 1'b0;
   logic                 out_valid;
   logic [N*DW-1:0]      frame_out;
   logic                 overrun;
`ifdef DESERIAL_LEN_CHECK_EN
   logic                 err_len;
`endif

   int checks = 0;
   int errors = 0;

   dense_deserial #(.N(N), .DW(DW)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .valid_in       (valid_in),
      .frame_start_in (frame_start_in),
      .frame_end_in   (frame_end_in),
      .data_in        (data_in),
      .out_ready      (out_ready),
      .out_valid      (out_valid),
      .frame_out      (frame_out),
`ifdef DESERIAL_LEN_CHECK_EN
      .overrun        (overrun),
      .err_len        (err_len)
`else
      .overrun        (overrun)
`endif
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   logic signed [DW-1:0] cur[$];
   bit                   m_coll = 0;
   bit                   m_hold = 0;
   bit                   exp_ovr = 0;
   bit                   exp_err = 0;
   logic [N*DW-1:0]      exp_frame = '0;

   function automatic int getw(input logic [N*DW-1:0] f, input int k);
      logic signed [DW-1:0] w;
      w = f[k*DW +: DW];
      return int'(w);
   endfunction

   task automatic m_word(input bit s, input bit e, input logic signed [DW-1:0] d);
      bit bad;
      bad = 0;
      if (s) begin
         cur.delete();
         cur.push_back(d);
         m_coll = 1;
      end else if (!m_coll) begin
         return;
      end else if (cur.size() < N) begin
         cur.push_back(d);
      end else begin
         bad = 1;
      end
`ifdef DESERIAL_LEN_CHECK_EN
      if (bad || (e && cur.size() != N)) begin
         exp_err = 1;
         m_coll  = 0;
         cur.delete();
         return;
      end
`endif
      if (e) begin
         exp_frame = '0;
         foreach (cur[k]) exp_frame[k*DW +: DW] = cur[k];
         m_hold = 1;
         m_coll = 0;
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur.delete();
         m_coll = 0; m_hold = 0; exp_ovr = 0; exp_err = 0; exp_frame = '0;
      end else begin
         exp_ovr = 0;
         exp_err = 0;
         if (m_hold) begin
            if (out_ready) begin
               m_hold = 0;
               cur.delete();
               if (valid_in && frame_start_in) m_word(1'b1, frame_end_in, data_in);
               else if (valid_in)              exp_ovr = 1;
            end else if (valid_in) begin
               exp_ovr = 1;
            end
         end else if (valid_in) begin
            m_word(frame_start_in, frame_end_in, data_in);
         end
      end
   end

   // ---------------- per-cycle comparison ----------------
   always @(negedge clk) begin
      if (rst_n) begin
         checks++;
         if (out_valid !== m_hold) begin
            errors++;
            $display("FAIL out_valid: got %0b expected %0b at %0t", out_valid, m_hold, $time);
         end
         checks++;
         if (overrun !== exp_ovr) begin
            errors++;
            $display("FAIL overrun: got %0b expected %0b at %0t", overrun, exp_ovr, $time);
         end
`ifdef DESERIAL_LEN_CHECK_EN
         checks++;
         if (err_len !== exp_err) begin
            errors++;
            $display("FAIL err_len: got %0b expected %0b at %0t", err_len, exp_err, $time);
         end
`endif
         if (m_hold) begin
            checks++;
            if (frame_out !== exp_frame) begin
               errors++;
               $display("FAIL frame_out: got w0=%0d w119=%0d expected w0=%0d w119=%0d at %0t",
                        getw(frame_out, 0), getw(frame_out, N-1),
                        getw(exp_frame, 0), getw(exp_frame, N-1), $time);
            end
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic drive(input bit v, input bit s, input bit e, input int d, input bit r);
      valid_in       = v;
      frame_start_in = s;
      frame_end_in   = e;
      data_in        = d[DW-1:0];
      out_ready      = r;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n, input bit r);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 0, r);
   endtask

   logic [N*DW-1:0] snap;
   int              ovr_cnt;

   initial begin
      // Reset state
      idle(3, 1'b0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_overrun", int'(overrun), 0);
      chk("rst_frame_zero", int'(frame_out == '0), 1);
      rst_n = 1'b1;
      idle(2, 1'b1);

      // 120 consecutive words 1..120, out_ready high
      for (int k = 0; k < N; k++) drive(1'b1, k == 0, k == N-1, k + 1, 1'b1);
      chk("full_valid", int'(out_valid), 1);
      chk("full_w0", getw(frame_out, 0), 1);
      chk("full_w57", getw(frame_out, 57), 58);
      chk("full_w119", getw(frame_out, 119), 120);
      idle(1, 1'b1);
      chk("full_valid_drop", int'(out_valid), 0);

      // Gappy frame, out_ready low for 10 cycles
      for (int k = 0; k < N; k++) begin
         drive(1'b1, k == 0, k == N-1, 500 + k, 1'b0);
         if (k % 7 == 3) idle(1, 1'b0);
      end
      snap = frame_out;
      for (int i = 0; i < 10; i++) begin
         chk("hold_valid", int'(out_valid), 1);
         chk("hold_stable", int'(frame_out == snap), 1);
         idle(1, 1'b0);
      end
      chk("hold_w3", getw(frame_out, 3), 503);
      idle(1, 1'b1);
      chk("hold_accepted", int'(out_valid), 0);

      // Partial frame abandoned by a new start
      for (int k = 0; k < 50; k++) drive(1'b1, k == 0, 1'b0, 1000 + k, 1'b1);
      for (int k = 0; k < N; k++) drive(1'b1, k == 0, k == N-1, -3 * (k + 1), 1'b1);
      chk("restart_w0", getw(frame_out, 0), -3);
      chk("restart_w49", getw(frame_out, 49), -150);
      chk("restart_w119", getw(frame_out, 119), -360);
      idle(2, 1'b1);

      // Words arriving while holding are dropped with overrun
      for (int k = 0; k < N; k++) drive(1'b1, k == 0, k == N-1, 7 * k, 1'b0);
      snap = frame_out;
      ovr_cnt = 0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, 1'b0, 16'h55, 1'b0);
         ovr_cnt += int'(overrun);
      end
      idle(1, 1'b0);
      chk("ovr_pulses", ovr_cnt, 3);
      chk("ovr_cleared", int'(overrun), 0);
      chk("ovr_frame_kept", int'(frame_out == snap), 1);
      chk("ovr_w10", getw(frame_out, 10), 70);

      // Handshake coincident with a new frame start
      drive(1'b1, 1'b1, 1'b0, 77, 1'b1);
      chk("hs_start_valid", int'(out_valid), 0);
      for (int k = 1; k < N; k++) drive(1'b1, 1'b0, k == N-1, 77 + k, 1'b0);
      chk("hs_new_valid", int'(out_valid), 1);
      chk("hs_w0", getw(frame_out, 0), 77);
      chk("hs_w1", getw(frame_out, 1), 78);
      chk("hs_w119", getw(frame_out, 119), 196);
      idle(2, 1'b1);

      // Short 80-word frame
      for (int k = 0; k < 80; k++) drive(1'b1, k == 0, k == 79, k + 1, 1'b1);
`ifdef DESERIAL_LEN_CHECK_EN
      chk("short_err", int'(err_len), 1);
      chk("short_no_valid", int'(out_valid), 0);
`else
      chk("short_valid", int'(out_valid), 1);
      chk("short_w79", getw(frame_out, 79), 80);
      chk("short_w80", getw(frame_out, 80), 0);
      chk("short_w119", getw(frame_out, 119), 0);
`endif
      idle(2, 1'b1);

      // Overlong frame: words past N never land
      for (int k = 0; k < N + 5; k++) drive(1'b1, k == 0, k == N+4, 2 * k, 1'b1);
`ifndef DESERIAL_LEN_CHECK_EN
      chk("long_valid", int'(out_valid), 1);
      chk("long_w119", getw(frame_out, 119), 238);
`endif
      idle(2, 1'b1);

      // Asynchronous reset mid-frame discards the partial frame
      for (int k = 0; k < 60; k++) drive(1'b1, k == 0, 1'b0, 9, 1'b1);
      rst_n = 1'b0;
      #2;
      chk("arst_frame_zero", int'(frame_out == '0), 1);
      chk("arst_valid", int'(out_valid), 0);
      idle(1, 1'b1);
      rst_n = 1'b1;
      for (int k = 60; k < N; k++) drive(1'b1, 1'b0, k == N-1, 9, 1'b1);
      chk("arst_no_valid", int'(out_valid), 0);
      idle(2, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dense_deserial.md
DENSE_DESERIAL -- requirements
Module: dense_deserial

Interface
REQ-001 Parameter N, default 120, number of words per frame.
REQ-002 Parameter DW, default 16, word width in bits (signed).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 valid_in  input  1  data_in and frame markers are valid this cycle.
REQ-006 frame_start_in  input  1  qualifies the first word of a frame; meaningful only with valid_in.
REQ-007 frame_end_in  input  1  qualifies the last word of a frame; meaningful only with valid_in.
REQ-008 data_in  input  DW  serial signed word.
REQ-009 out_ready  input  1  downstream accepts frame_out.
REQ-010 out_valid  output  1  frame_out holds a complete frame.
REQ-011 frame_out  output  N*DW  parallel frame; word k at bits [k*DW+DW-1 : k*DW], word 0 is the first received.
REQ-012 overrun  output  1  one-cycle pulse: a valid_in word was dropped.

Function
REQ-013 The block SHALL implement a three-state FSM: IDLE, COLLECT, HOLD.
REQ-014 IDLE: valid_in&frame_start_in SHALL write data_in to word 0, clear words 1..N-1, set count=1 and go to COLLECT; valid_in without frame_start_in SHALL be ignored silently.
REQ-015 COLLECT: each valid_in without frame_start_in SHALL write data_in to word[count] and increment count.
REQ-016 COLLECT: valid_in&frame_start_in SHALL discard the partial frame and restart exactly as in REQ-014.
REQ-017 valid_in&frame_end_in in COLLECT (or with frame_start_in in IDLE, for N=1) SHALL write the word and go to HOLD; out_valid SHALL rise on the next clock edge (latency 1 cycle after the last word).
REQ-018 COLLECT: words arriving when count==N SHALL NOT be written; count SHALL saturate at N.
REQ-019 HOLD: out_valid SHALL stay high and frame_out SHALL stay stable until out_valid&out_ready.
REQ-020 HOLD with out_ready=1: handshake completes; if valid_in&frame_start_in occur the same cycle, that word SHALL be accepted (go to COLLECT), otherwise go to IDLE.
REQ-021 HOLD: any other valid_in word SHALL be dropped and SHALL pulse overrun on the next cycle.
REQ-022 frame_end_in without valid_in SHALL have no effect; count width SHALL be clog2(N+1).

Reset
REQ-023 On rst_n low: state=IDLE, count=0, out_valid=0, overrun=0, frame_out all zeros; rst_n assertion mid-frame or in HOLD SHALL discard the frame with no out_valid.

Configuration
REQ-024 Macro DESERIAL_LEN_CHECK_EN SHALL add output err_len (1-bit) after overrun.
REQ-025 With DESERIAL_LEN_CHECK_EN: frame_end with count+1 != N, or a word arriving at count==N, SHALL pulse err_len one cycle later, discard the frame and go to IDLE (no out_valid).
REQ-026 Without DESERIAL_LEN_CHECK_EN: short frames SHALL be presented with unwritten words zero; overlong words follow REQ-018; no err_len port.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding and default N/DW constants, also used by dense1 serializer logic.
REQ-028 The block SHALL be a single module; no sub-module.

Verification
REQ-029 120 consecutive words 1..120, start on first, end on last, out_ready=1 -> out_valid pulses once 1 cycle after the last word; word k = k+1.
REQ-030 Frame with valid_in gaps and out_ready held low 10 cycles -> out_valid held 10+ cycles, frame_out stable, accepted on first out_ready.
REQ-031 Start, 50 words, new start, 120 words -> only the second frame presented; word 0 = second start's data.
REQ-032 In HOLD, 3 valid_in words, out_ready=0 -> 3 overrun pulses; held frame unchanged.
REQ-033 Handshake cycle coincident with new frame_start -> new frame word 0 captured, next frame completes normally.
REQ-034 80-word frame: with DESERIAL_LEN_CHECK_EN -> err_len pulse, no out_valid; without -> out_valid, words 80..119 = 0.
